// File: rtl/led_seq_pkg.sv
// Shared state type, default parameter values and width helper for the LED trigger sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFire    = 2'd1,
    StWaitEnd = 2'd2,
    StGap     = 2'd3
  } seq_state_e;

  localparam int unsigned DefDebounceCycles = 16;
  localparam int unsigned DefMaxPending     = 7;
  localparam int unsigned DefCntW           = 3;
  localparam int unsigned DefGapCycles      = 4;
  localparam int unsigned DefTimeoutCycles  = 4096;

  // Bits needed for a counter that runs 0 .. n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Raw button -> 2-flop synchronizer -> stability debounce -> one-cycle rising-edge press.
module btn_debouncer
  import led_seq_pkg::*;
#(
  parameter int unsigned DebounceCycles = DefDebounceCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned   DbW    = cnt_width(DebounceCycles);
  localparam logic [DbW-1:0] DbLast = DbW'(DebounceCycles - 1);

  logic           sync1_q;
  logic           btn_s_q;
  logic           btn_clean_q;
  logic           clean_prev_q;
  logic [DbW-1:0] db_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      btn_s_q      <= 1'b0;
      btn_clean_q  <= 1'b0;
      clean_prev_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      sync1_q      <= btn_i;
      btn_s_q      <= sync1_q;
      clean_prev_q <= btn_clean_q;
      // Any cycle where the synced input agrees with the clean level restarts the count.
      if (btn_s_q == btn_clean_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbLast) begin
        btn_clean_q <= btn_s_q;
        db_cnt_q    <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign press_o = btn_clean_q & ~clean_prev_q;

endmodule

// File: rtl/led_trigger_sequencer.sv
// Queues debounced button presses and fires one led_on per press, pacing against led_end.
// Optional WAIT_END watchdog enabled by defining LED_TIMEOUT_EN.
module led_trigger_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned DebounceCycles = DefDebounceCycles,
  parameter int unsigned MaxPending     = DefMaxPending,
  parameter int unsigned CntW           = DefCntW,
  parameter int unsigned GapCycles      = DefGapCycles,
  parameter int unsigned TimeoutCycles  = DefTimeoutCycles
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn,
  input  logic            led_end,
  output logic            led_on,
  output logic            busy,
  output logic [CntW-1:0] pending,
  output logic            overflow,
  output logic            timeout_err
);

  localparam int unsigned    GapW    = cnt_width(GapCycles);
  localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);
  localparam logic [CntW-1:0] PendMax = CntW'(MaxPending);

  logic            press;
  logic            dequeue;
  seq_state_e      state_q;
  logic [CntW-1:0] pending_q;
  logic            led_on_q;
  logic            busy_q;
  logic            overflow_q;
  logic [GapW-1:0] gap_cnt_q;

  btn_debouncer #(
    .DebounceCycles(DebounceCycles)
  ) u_debouncer (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn),
    .press_o(press)
  );

  assign dequeue = (state_q == StIdle) && (pending_q != '0);

  // Simultaneous press and dequeue cancel out, so a full queue cannot overflow then.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      case ({press, dequeue})
        2'b10: begin
          if (pending_q == PendMax) overflow_q <= 1'b1;
          else                      pending_q  <= pending_q + 1'b1;
        end
        2'b01:   pending_q <= pending_q - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef LED_TIMEOUT_EN
  localparam int unsigned    TmoW    = cnt_width(TimeoutCycles);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            timeout_q;

  assign timeout_err = timeout_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TimeoutCycles;
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      led_on_q  <= 1'b0;
      busy_q    <= 1'b0;
      gap_cnt_q <= '0;
`ifdef LED_TIMEOUT_EN
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      led_on_q <= 1'b0;
`ifdef LED_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (dequeue) begin
            state_q  <= StFire;
            led_on_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StFire: begin
          state_q <= StWaitEnd;
`ifdef LED_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        StWaitEnd: begin
          gap_cnt_q <= '0;
          if (led_end) begin
            state_q <= StGap;
          end
`ifdef LED_TIMEOUT_EN
          else if (tmo_cnt_q == TmoLast) begin
            state_q   <= StGap;
            timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign led_on   = led_on_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_led_trigger_sequencer.sv
// Directed bench for led_trigger_sequencer: debounce, queueing, pacing, reset abort, watchdog.
module tb_led_trigger_sequencer;

  localparam int Gap = 4;
  localparam int Tmo = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic       led_end = 1'b0;
  logic       led_on, busy, overflow, timeout_err;
  logic [2:0] pending;

  logic       t_led_end = 1'b0;
  logic       t_led_on, t_busy, t_overflow, t_timeout_err;
  logic [2:0] t_pending;

  int n_vec = 0;
  int n_err = 0;

  int n_on = 0, n_ovf = 0, n_tmo = 0, n_pend_nz = 0, b2b = 0;
  int low_run = 0, min_gap = 1000;
  bit prev_on = 1'b0, seen_on = 1'b0;

  always #5 clk = ~clk;

  led_trigger_sequencer #(
    .GapCycles(Gap)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .led_end    (led_end),
    .led_on     (led_on),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  // Second instance with a short watchdog; its led_end is never pulsed.
  led_trigger_sequencer #(
    .GapCycles    (Gap),
    .TimeoutCycles(Tmo)
  ) dut_tmo (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .led_end    (t_led_end),
    .led_on     (t_led_on),
    .busy       (t_busy),
    .pending    (t_pending),
    .overflow   (t_overflow),
    .timeout_err(t_timeout_err)
  );

  always @(negedge clk) begin
    if (led_on) begin
      n_on++;
      if (prev_on) b2b++;
      if (seen_on && low_run < min_gap) min_gap = low_run;
      seen_on = 1'b1;
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_on = led_on;
    if (overflow) n_ovf++;
    if (t_timeout_err) n_tmo++;
    if (pending != 3'd0) n_pend_nz++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic press_btn();
    btn = 1'b1;
    repeat (20) @(negedge clk);
    btn = 1'b0;
    repeat (22) @(negedge clk);
  endtask

  // Pulse led_end now and watch the following cycles for the gap and any refire.
  task automatic end_and_watch(input int limit, output int k_on, output int pend_on);
    k_on    = 0;
    pend_on = 0;
    led_end = 1'b1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) led_end = 1'b0;
      if (k == Gap) check_eq("gap_busy_hi", busy, 1);
      if (k == Gap + 1) check_eq("gap_busy_lo", busy, 0);
      if (led_on && k_on == 0) begin
        k_on    = k;
        pend_on = pending;
      end
    end
  endtask

  initial begin
    int k, k_on, pend_on, on0, ov0, nz0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_led_on", led_on, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_timeout", timeout_err, 0);

    // 1: single clean press
    btn = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (pending == 3'd0 && k < 40);
    check_eq("press_latency", k, 19);
    check_eq("p1_led_on_early", led_on, 0);
    check_eq("p1_busy_early", busy, 0);
    @(negedge clk);
    check_eq("p1_pending_deq", pending, 0);
    check_eq("p1_led_on", led_on, 1);
    check_eq("p1_busy", busy, 1);
    @(negedge clk);
    check_eq("p1_led_on_single", led_on, 0);
    check_eq("p1_busy_wait", busy, 1);
    btn = 1'b0;
    repeat (25) @(negedge clk);
    check_eq("p1_hold_busy", busy, 1);
    check_eq("p1_on_count", n_on, 1);
    end_and_watch(12, k_on, pend_on);
    check_eq("p1_no_refire", k_on, 0);

    // 2: short glitch is rejected
    on0 = n_on;
    nz0 = n_pend_nz;
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("glitch_pending_seen", n_pend_nz - nz0, 0);
    check_eq("glitch_led_on", n_on - on0, 0);
    check_eq("glitch_busy", busy, 0);

    // 3: saturation while WAIT_END stalls
    on0 = n_on;
    press_btn();
    check_eq("s3_first_fire", n_on - on0, 1);
    ov0 = n_ovf;
    for (int p = 1; p <= 9; p++) begin
      press_btn();
      check_eq($sformatf("s3_pending_%0d", p), pending, (p > 7) ? 7 : p);
      check_eq($sformatf("s3_overflow_%0d", p), n_ovf - ov0, (p > 7) ? p - 7 : 0);
    end
    for (int j = 0; j < 7; j++) begin
      end_and_watch(12, k_on, pend_on);
      check_eq($sformatf("s3_fire_lat_%0d", j), k_on, Gap + 2);
      check_eq($sformatf("s3_pend_%0d", j), pend_on, 6 - j);
    end
    end_and_watch(12, k_on, pend_on);
    check_eq("s3_drained", k_on, 0);
    check_eq("s3_total_fires", n_on - on0, 8);

    // 4: press lands on the IDLE->FIRE dequeue cycle with pending=1
    press_btn();
    press_btn();
    check_eq("s4_pre_pending", pending, 1);
    ov0 = n_ovf;
    btn = 1'b1;
    repeat (13) @(negedge clk);
    end_and_watch(12, k_on, pend_on);
    btn = 1'b0;
    check_eq("s4_fire_lat", k_on, Gap + 2);
    check_eq("s4_pending_held", pend_on, 1);
    check_eq("s4_no_overflow", n_ovf - ov0, 0);
    repeat (25) @(negedge clk);
    end_and_watch(12, k_on, pend_on);
    check_eq("s4_second_fire", k_on, Gap + 2);
    check_eq("s4_second_pend", pend_on, 0);
    end_and_watch(12, k_on, pend_on);
    check_eq("s4_drained", k_on, 0);

    // 5: reset during WAIT_END with pending=3
    press_btn();
    for (int p = 0; p < 3; p++) press_btn();
    check_eq("s5_pending", pending, 3);
    check_eq("s5_busy", busy, 1);
    on0 = n_on;
    reset = 1'b1;
    @(negedge clk);
    check_eq("s5_rst_pending", pending, 0);
    check_eq("s5_rst_busy", busy, 0);
    check_eq("s5_rst_led_on", led_on, 0);
    reset = 1'b0;
    led_end = 1'b1;
    @(negedge clk);
    led_end = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("s5_no_fire", n_on - on0, 0);
    check_eq("s5_idle", busy, 0);
    check_eq("s5_pending_after", pending, 0);

    // 6: watchdog on the short-timeout instance
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    btn = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!t_led_on && k < 60);
    check_eq("s6_fire_lat", k, 20);
    btn = 1'b0;
`ifdef LED_TIMEOUT_EN
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!t_timeout_err && k < 200);
    check_eq("s6_tmo_lat", k, Tmo + 1);
    @(negedge clk);
    check_eq("s6_tmo_single", t_timeout_err, 0);
    repeat (2) @(negedge clk);
    check_eq("s6_gap_busy", t_busy, 1);
    @(negedge clk);
    check_eq("s6_idle", t_busy, 0);
`else
    repeat (100) @(negedge clk);
    check_eq("s6_stuck_busy", t_busy, 1);
    check_eq("s6_no_tmo", n_tmo, 0);
`endif

    check_eq("no_back_to_back", b2b, 0);
    check_eq("min_low_gap_ok", (min_gap >= Gap + 2) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
